mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mmips_pkg.sv | 25 ++
 rtl/mem_arb_timer.sv | 45 ++++
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmips_pkg.sv
// rtl/mmips_pkg.sv - shared types and defaults for the memory arbiter
package mmips_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int WAIT_CNT_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // D wins a tie unless the caller asks for the fetch side to be preferred.
  function automatic owner_t pick_owner(input logic i_req, input logic d_req,
                                        input logic prefer_i);
    return (d_req && !(i_req && prefer_i)) ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// rtl/mem_arb_timer.sv - saturating BUSY-cycle counter with sticky timeout flag
// timeout is already high during the MAX_WAIT-th BUSY cycle, then held until rst.
module mem_arb_timer
  import mmips_pkg::*;
#(
  parameter int MAX_WAIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic timeout
);

  localparam logic [WAIT_CNT_W-1:0] LIMIT    = WAIT_CNT_W'(MAX_WAIT);
  localparam logic [WAIT_CNT_W-1:0] LIMIT_M1 = WAIT_CNT_W'(MAX_WAIT - 1);

  logic [WAIT_CNT_W-1:0] count_q, count_d;
  logic                  sticky_q, sticky_d;
  logic                  hit;

  always_comb begin
    hit      = run && (count_q >= LIMIT_M1);
    count_d  = count_q;
    sticky_d = sticky_q | hit;
    if (clear) begin
      count_d = '0;
    end else if (run && (count_q != LIMIT)) begin
      count_d = count_q + WAIT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

  assign timeout = sticky_q | hit;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto one shared memory port
// Optional MMIPS_ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests.
module mem_arbiter
  import mmips_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_wait,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_wait,
  output logic                m_req,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_be,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready,
  output logic                timeout
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t          state_q, state_d;
  owner_t              owner_q, owner_d;
  owner_t              grant_own;
  logic                grant;
  logic                prefer_i;
  logic                m_req_q, m_req_d;
  logic                m_we_q, m_we_d;
  logic [BE_W-1:0]     m_be_q, m_be_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

`ifdef MMIPS_ARB_ROUND_ROBIN_EN
  owner_t last_q, last_d;

  assign prefer_i = (last_q == OWN_D);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= OWN_I;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    last_d = last_q;
    if (grant) begin
      last_d = grant_own;
    end
  end
`else
  assign prefer_i = 1'b0;
`endif

  assign grant_own = pick_owner(i_req, d_req, prefer_i);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    grant     = 1'b0;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_be_d    = m_be_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          grant   = 1'b1;
          state_d = BUSY;
          owner_d = grant_own;
          m_req_d = 1'b1;
          if (grant_own == OWN_D) begin
            m_we_d    = d_we;
            m_be_d    = d_be;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
          end else begin
            m_we_d    = 1'b0;
            m_be_d    = '1;
            m_addr_d  = i_addr;
            m_wdata_d = '0;
          end
        end
      end
      BUSY: begin
        // Requester inputs are deliberately not looked at here; the grant is committed.
        if (m_ready) begin
          state_d = DONE;
          m_req_d = 1'b0;
          if (owner_q == OWN_D) begin
            d_rdata_d = m_rdata;
          end else begin
            i_rdata_d = m_rdata;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_D;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_be_q    <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_be_q    <= m_be_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  mem_arb_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (grant),
    .run     (state_q == BUSY),
    .timeout (timeout)
  );

  // Wait drops for exactly the DONE cycle so the owning pipeline stage can advance.
  assign i_wait  = i_req & ~((state_q == DONE) && (owner_q == OWN_I));
  assign d_wait  = d_req & ~((state_q == DONE) && (owner_q == OWN_D));
  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_be    = m_be_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter (MAX_WAIT=4)
// Honours MMIPS_ARB_ROUND_ROBIN_EN in its reference model.
module tb_mem_arbiter;

  localparam int MAX_WAIT = 4;
  localparam int S_IDLE = 0;
  localparam int S_BUSY = 1;
  localparam int S_DONE = 2;
`ifdef MMIPS_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we, m_ready;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [3:0]  d_be;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_wait, d_wait, m_req, m_we, timeout;
  logic [3:0]  m_be;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_wait(i_wait),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_wait(d_wait),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .timeout(timeout)
  );

  typedef struct {
    bit          own_d;
    logic [31:0] addr;
    bit          we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } grant_t;

  typedef struct {
    bit          i_wait, d_wait, m_req, timeout, mzero;
    logic [31:0] i_rdata, d_rdata;
  } cyc_t;

  grant_t grant_q[$];
  cyc_t   cyc_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;

  // Reference model: transaction-level view of the shared port.
  int          md_st = S_IDLE;
  int          md_bn = 0;
  bit          md_own_d = 1'b0, md_last_d = 1'b0, md_tmo = 1'b0, md_mzero = 1'b1;
  logic [31:0] md_irdata = '0, md_drdata = '0;
  bit          done_i = 1'b0, done_d = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    grant_t g;
    cyc_t   c;
    bit     take_d;
    if (rst) begin
      md_st = S_IDLE; md_bn = 0; md_tmo = 1'b0; md_last_d = 1'b0; md_mzero = 1'b1;
      md_irdata = '0; md_drdata = '0;
    end else if (md_st == S_IDLE) begin
      if (i_req || d_req) begin
        take_d  = d_req && !(i_req && RR_EN && md_last_d);
        g.own_d = take_d;
        g.addr  = take_d ? d_addr : i_addr;
        g.we    = take_d ? d_we : 1'b0;
        g.be    = take_d ? d_be : 4'hF;
        g.wdata = take_d ? d_wdata : 32'h0;
        grant_q.push_back(g);
        md_st = S_BUSY; md_own_d = take_d; md_last_d = take_d; md_bn = 1; md_mzero = 1'b0;
      end
    end else if (md_st == S_BUSY) begin
      if (md_bn >= MAX_WAIT) md_tmo = 1'b1;
      if (m_ready) begin
        if (md_own_d) md_drdata = m_rdata;
        else md_irdata = m_rdata;
        md_st = S_DONE;
      end else begin
        md_bn++;
      end
    end else begin
      md_st = S_IDLE;
    end
    done_i = (md_st == S_DONE) && !md_own_d;
    done_d = (md_st == S_DONE) && md_own_d;
    c.i_wait  = i_req && !done_i;
    c.d_wait  = d_req && !done_d;
    c.m_req   = (md_st == S_BUSY);
    c.timeout = md_tmo || ((md_st == S_BUSY) && (md_bn >= MAX_WAIT));
    c.mzero   = md_mzero;
    c.i_rdata = md_irdata;
    c.d_rdata = md_drdata;
    cyc_q.push_back(c);
    @(negedge clk);
  endtask

  // Drive m_ready after lat idle BUSY cycles; retire each port when its DONE arrives.
  task automatic serve(input int lat);
    int guard = 0;
    int busy_n = 0;
    while ((i_req || d_req) && guard < 200) begin
      if (md_st == S_BUSY) begin
        m_ready = (busy_n >= lat);
        busy_n  = m_ready ? 0 : busy_n + 1;
      end else begin
        m_ready = 1'b0;
        busy_n  = 0;
      end
      m_rdata = $urandom;
      tick();
      guard++;
      if (done_i) i_req = 1'b0;
      if (done_d) d_req = 1'b0;
    end
    if (guard >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL serve_bound: got %0d cycles expected < 200", guard);
    end
    m_ready = 1'b0;
    tick();
  endtask

  cyc_t   mon_c;
  grant_t mon_held;
  bit     mon_prev = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (cyc_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL cyc_underflow: got 0 expected entries at %0t", $time);
      end else begin
        mon_c = cyc_q.pop_front();
        chk("i_wait", i_wait, mon_c.i_wait);
        chk("d_wait", d_wait, mon_c.d_wait);
        chk("m_req", m_req, mon_c.m_req);
        chk("timeout", timeout, mon_c.timeout);
        chk("i_rdata", i_rdata, mon_c.i_rdata);
        chk("d_rdata", d_rdata, mon_c.d_rdata);
        if (mon_c.mzero) begin
          chk("rst_m_we", m_we, 0);
          chk("rst_m_be", m_be, 0);
          chk("rst_m_addr", m_addr, 0);
          chk("rst_m_wdata", m_wdata, 0);
        end
      end
      if (m_req && !mon_prev) begin
        if (grant_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL grant_underflow: got m_req expected none at %0t", $time);
        end else begin
          mon_held = grant_q.pop_front();
        end
      end
      if (m_req) begin
        chk("m_addr", m_addr, mon_held.addr);
        chk("m_we", m_we, mon_held.we);
        chk("m_be", m_be, mon_held.be);
        if (mon_held.own_d) chk("m_wdata", m_wdata, mon_held.wdata);
      end
      mon_prev = m_req;
    end
  end

  initial begin
    logic [31:0] keep;
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = '0;
    i_addr = '0; d_addr = '0; d_wdata = '0; m_ready = 1'b1; m_rdata = 32'h5555_AAAA;
    tick(); tick();
    rst = 1'b0; m_ready = 1'b0;
    tick();

    // single fetch, minimum latency
    i_req = 1'b1; i_addr = 32'h0040_0000;
    tick();
    m_ready = 1'b1; m_rdata = 32'h2408_0005;
    tick();
    chk("req031_wait_done", i_wait, 0);
    chk("req031_rdata", i_rdata, 32'h2408_0005);
    i_req = 1'b0; m_ready = 1'b0;
    tick(); tick();

    // simultaneous pairs
    repeat (4) begin
      i_req = 1'b1; i_addr = $urandom;
      d_req = 1'b1; d_addr = 32'h1000_0010; d_we = 1'b0; d_be = 4'hF;
      serve(0);
    end

    // delayed store
    d_req = 1'b1; d_we = 1'b1; d_be = 4'h3; d_wdata = 32'hDEAD_BEEF; d_addr = 32'h1000_0020;
    serve(5);
    rst = 1'b1; tick(); rst = 1'b0; tick();

    // long wait sets sticky timeout
    i_req = 1'b1; i_addr = 32'h0040_0004;
    serve(10);
    tick();
    chk("req035_sticky", timeout, 1);
    rst = 1'b1; tick(); rst = 1'b0; tick();
    chk("req035_cleared", timeout, 0);

    // dropped request still completes
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000_0030;
    tick();
    d_req = 1'b0; tick();
    keep = $urandom; m_ready = 1'b1; m_rdata = keep; tick();
    m_ready = 1'b0; tick(); tick();
    chk("req018_rdata", d_rdata, keep);

    // reset mid-transaction, later m_ready ignored
    d_req = 1'b1; d_addr = 32'h1000_0040;
    tick(); tick();
    rst = 1'b1; d_req = 1'b0; tick();
    rst = 1'b0; m_ready = 1'b1; m_rdata = 32'hFFFF_FFFF; tick(); tick();
    m_ready = 1'b0; tick();
    chk("req036_m_req", m_req, 0);
    chk("req036_d_rdata", d_rdata, 0);

    // randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (done_i) begin
        i_req = $urandom_range(0, 1); i_addr = $urandom;
      end else if (!i_req) begin
        if ($urandom_range(0, 2) == 0) begin i_req = 1'b1; i_addr = $urandom; end
      end else if ($urandom_range(0, 39) == 0) begin
        i_req = 1'b0;
      end else if ($urandom_range(0, 19) == 0) begin
        i_addr = $urandom;
      end
      if (done_d || (!d_req && $urandom_range(0, 2) == 0)) begin
        d_req = done_d ? 1'($urandom_range(0, 1)) : 1'b1;
        d_addr = $urandom; d_we = $urandom_range(0, 1);
        d_be = $urandom_range(0, 15); d_wdata = $urandom;
      end else if (d_req && $urandom_range(0, 39) == 0) begin
        d_req = 1'b0;
      end else if (d_req && $urandom_range(0, 19) == 0) begin
        d_addr = $urandom; d_wdata = $urandom;
      end
      m_ready = ($urandom_range(0, 2) == 0);
      m_rdata = $urandom;
      tick();
    end

    rst = 1'b0; i_req = 1'b0; d_req = 1'b0; m_ready = 1'b0;
    repeat (20) tick();
    chk("grant_q_drained", grant_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
